// File: rtl/inst_mem_responder_pkg.sv
// rtl/inst_mem_responder_pkg.sv - shared types and constants for the instruction memory responder
//
// Purpose: state encoding for the load/serve FSM, default widths, and the
//          PC select codes shared with the fetch datapath.
package inst_mem_responder_pkg;

  typedef enum logic {
    ST_LOADING = 1'b0,
    ST_READY   = 1'b1
  } state_t;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 10;

  // PC source select codes used by the stage-0 fetch controller.
  localparam logic [1:0] PC_SEL_INC    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_HOLD   = 2'd2;

endpackage

// File: rtl/inst_mem_responder_inst_bram.sv
// rtl/inst_mem_responder_inst_bram.sv - simple dual-port instruction RAM with registered read
//
// Purpose: one write port, one read port with a registered output that is
//          updated only when re is high (holds otherwise). No reset on the
//          array or the output register so it maps onto block RAM.
// Ports:
//   clk           clock
//   we/waddr/wdata  write port
//   re/raddr      read enable and address; rdata valid one cycle after re
//   rdata         registered read data
module inst_bram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - fetch-side instruction memory with program loading and range fault
//
// Purpose: serves stage-0 instruction reads with 1-cycle latency and presents
//          a registered instruction to stage 1; owns program loading and
//          program length tracking; flags reads past the program end.
// Ports:
//   clk, rst (sync, active-low)
//   load_start, load_done   loader control pulses
//   wr_en/wr_addr/wr_data   host instruction writes (LOADING only)
//   rd_en/rd_addr           fetch request from stage 0
//   inst_ack                stage 1 consumed inst_out
//   inst_out, inst_valid    fetched instruction to stage 1
//   ready                   state == READY
//   fault                   sticky out-of-range fetch
//   inst_count              loaded program length
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_done,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  inst_ack,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic                  inst_valid,
  output logic                  ready,
  output logic                  fault,
  output logic [ADDR_WIDTH:0]   inst_count
);

  state_t                state;
  state_t                state_nxt;
  logic                  rd_go;
  logic                  in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH:0]   wr_len;
  logic                  out_zero;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = ST_LOADING;
    end else if (load_done && state == ST_LOADING) begin
      state_nxt = ST_READY;
    end
  end

  // A write coinciding with load_start belongs to the new program.
  assign mem_we   = rst && wr_en && (state == ST_LOADING || load_start);
  // A read coinciding with load_start is dropped.
  assign rd_go    = rd_en && (state == ST_READY) && !load_start;
  assign wr_len   = {1'b0, wr_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign in_range = {1'b0, rd_addr} < inst_count;

  inst_bram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bram (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re   (rst && rd_go),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  // The RAM output register has no reset and is overwritten on faulting
  // reads, so a registered mask flag aligned to the RAM stage forces zero.
  assign inst_out = out_zero ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_LOADING;
      ready      <= 1'b0;
      inst_valid <= 1'b0;
      out_zero   <= 1'b1;
      fault      <= 1'b0;
      inst_count <= '0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == ST_READY);
      if (load_start) begin
        inst_valid <= 1'b0;
        out_zero   <= 1'b1;
        fault      <= 1'b0;
        inst_count <= wr_en ? wr_len : '0;
      end else begin
        if (mem_we && wr_len > inst_count) begin
          inst_count <= wr_len;
        end
        if (rd_go) begin
          inst_valid <= in_range;
          out_zero   <= !in_range;
          if (!in_range) begin
            fault <= 1'b1;
          end
        end else if (inst_ack) begin
          inst_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - scoreboard testbench for inst_mem_responder
module tb_inst_mem_responder;

  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          load_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          inst_ack;
  logic [DW-1:0] inst_out;
  logic          inst_valid;
  logic          ready;
  logic          fault;
  logic [AW:0]   inst_count;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_done(load_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .inst_ack(inst_ack),
    .inst_out(inst_out), .inst_valid(inst_valid), .ready(ready),
    .fault(fault), .inst_count(inst_count)
  );

  function automatic logic [DW-1:0] mk(input int n);
    return 64'hC0DE_0000_0000_0000 | 64'(n);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each edge that sees rd_en pops one expected response.
  initial begin
    forever begin
      logic took;
      exp_t e;
      @(posedge clk);
      took = rd_en;
      #1;
      if (took) begin
        if (q.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rd_valid", inst_valid, e.v);
          chk("rd_data", inst_out, e.d);
          chk("rd_fault", fault, e.f);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic rd(input int a, input logic v, input logic [DW-1:0] d, input logic f);
    exp_t e;
    e.v = v; e.d = d; e.f = f;
    q.push_back(e);
    rd_en = 1; rd_addr = AW'(a);
    tick();
    rd_en = 0;
  endtask

  task automatic pulse_done();
    load_done = 1;
    tick();
    load_done = 0;
  endtask

  initial begin
    rst = 0; load_start = 0; load_done = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    rd_en = 0; rd_addr = '0; inst_ack = 0;
    tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_fault", fault, 0);
    chk("rst_count", inst_count, 0);
    rst = 1;

    for (int i = 0; i < 4; i++) wr(i, mk(i + 1));
    chk("load_count", inst_count, 4);
    pulse_done();
    chk("done_ready", ready, 1);
    chk("done_count", inst_count, 4);
    chk("done_fault", fault, 0);
    chk("done_valid", inst_valid, 0);

    rd(2, 1, mk(3), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", inst_valid, 1);
      chk("hold_out", inst_out, mk(3));
    end
    inst_ack = 1;
    tick();
    inst_ack = 0;
    chk("ack_clear", inst_valid, 0);
    chk("ack_out_hold", inst_out, mk(3));

    inst_ack = 1;
    for (int i = 0; i < 3; i++) rd(i, 1, mk(i + 1), 0);
    inst_ack = 0;
    chk("b2b_valid_held", inst_valid, 1);
    inst_ack = 1;
    tick();
    inst_ack = 0;

    wr(0, 64'hDEAD_BEEF_DEAD_BEEF);
    wr(5, 64'h1234);
    chk("ready_wr_count", inst_count, 4);
    rd(0, 1, mk(1), 0);

    rd(4, 0, 64'h0, 1);
    rd(1, 1, mk(2), 1);
    rd(5, 0, 64'h0, 1);
    tick();
    chk("fault_sticky", fault, 1);

    load_start = 1; load_done = 1;
    tick();
    load_start = 0; load_done = 0;
    chk("restart_ready", ready, 0);
    chk("restart_fault", fault, 0);
    chk("restart_count", inst_count, 0);
    chk("restart_valid", inst_valid, 0);
    chk("restart_out", inst_out, 0);

    rd(0, 0, 64'h0, 0);

    wr(1023, mk(77));
    chk("full_count", inst_count, 1024);
    wr(3, mk(4));
    chk("max_count", inst_count, 1024);
    pulse_done();
    rd(1023, 1, mk(77), 0);

    rst = 0;
    q.push_back('{v: 1'b0, d: 64'h0, f: 1'b0});
    rd_en = 1; rd_addr = AW'(1023);
    tick();
    rd_en = 0;
    rst = 1;
    chk("midrd_rst_ready", ready, 0);
    chk("midrd_rst_count", inst_count, 0);

    pulse_done();
    chk("empty_ready", ready, 1);
    rd(0, 0, 64'h0, 1);

    load_start = 1; wr_en = 1; wr_addr = AW'(6); wr_data = mk(66);
    tick();
    load_start = 0; wr_en = 0;
    chk("start_wr_count", inst_count, 7);
    chk("start_wr_fault", fault, 0);
    pulse_done();
    rd(6, 1, mk(66), 0);

    tick(); tick();
    chk("queue_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Responder end of the fetch interface: serves instruction reads issued by the stage-0 fetch controller (read enable plus the PC as address) and presents a registered 64-bit BPF instruction to stage 1.
- Also owns program loading: while in LOADING, the host writes instructions, and the block tracks the program length.
- Reads past the end of the loaded program are trapped with a sticky fault.
- Sits between the datapath's PC/fetch controller and the stage-1 decode controller.

Parameters:
ADDR_WIDTH, 10, instruction address width (depth = 2^ADDR_WIDTH words)
DATA_WIDTH, 64, instruction word width (BPF encoding)

Ports:
clk  input  1  single clock
rst  input  1  reset, synchronous, active-low (0 = reset)
load_start  input  1  pulse: enter LOADING, clear program length and fault
load_done  input  1  pulse: LOADING -> READY
wr_en  input  1  host instruction write, honoured only in LOADING
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  instruction to write
rd_en  input  1  fetch read request (from stage-0 controller)
rd_addr  input  ADDR_WIDTH  fetch address (PC)
inst_ack  input  1  stage 1 has consumed inst_out this cycle
inst_out  output  DATA_WIDTH  fetched instruction
inst_valid  output  1  inst_out holds an unconsumed instruction
ready  output  1  state == READY
fault  output  1  sticky out-of-range fetch
inst_count  output  ADDR_WIDTH+1  loaded program length

Behaviour:
- Reset (rst == 0 at a clk edge): state = LOADING, inst_out = 0, inst_valid = 0, ready = 0, fault = 0, inst_count = 0. RAM contents are not reset.
- States: LOADING, READY. ready is a registered copy of (state == READY).
- LOADING -> READY on load_done. Any state -> LOADING on load_start. load_start wins if asserted in the same cycle as load_done.
- load_start also clears inst_valid, inst_out, fault and inst_count on the following edge. A read in flight that cycle is discarded.
- Writes: in LOADING with wr_en, mem[wr_addr] <= wr_data, and inst_count <= max(inst_count, wr_addr+1), computed at ADDR_WIDTH+1 bits with no wrap (full depth gives 2^ADDR_WIDTH).
  - In READY, wr_en is ignored: no memory change, no count change.
  - A write in the same cycle as load_start is applied and counted from 0.
- Reads: honoured only in READY. rd_en in LOADING is ignored; inst_valid stays 0.
- Read latency is 1 cycle. With rd_en=1 at edge N, at edge N+1:
  - if rd_addr < inst_count: inst_out = mem[rd_addr], inst_valid = 1.
  - else: inst_out = 0, inst_valid = 0, fault = 1 (sticky until load_start or reset).
- Hold: with rd_en=0, inst_out holds its value. inst_valid clears on the edge after inst_ack=1, otherwise holds. This covers a stalled stage 1.
- Simultaneous rd_en=1 and inst_ack=1: the new read wins (inst_valid=1 with new data).
- rd_en=1 while inst_valid=1 and inst_ack=0: the new read overwrites. The fetch controller guarantees this does not occur while stage 1 is stalled; the block does not flag it.
- While fault=1, reads continue to be served normally. fault is only a flag; the CPU controller decides to halt.
- load_done with inst_count == 0 is legal: the block enters READY and every read faults.
- Address wrap: rd_addr and wr_addr are plain ADDR_WIDTH-bit values; no wrap logic is needed.

Decomposition:
- Shared package/header: state encoding (ST_LOADING=0, ST_READY=1) and DATA_WIDTH default constant, alongside the existing PC_SEL_* defines.
- One sub-module, inst_bram: simple dual-port RAM.
  - One write port, one read port with registered output, 1-cycle latency, read-enable gated.
  - Inferable as block RAM.
  - The range check and valid/fault registers stay in the parent, aligned to the RAM output stage.

Test Plan:
- Reset, then load mem[0..3] = 0x..01..0x..04 and pulse load_done -> ready=1 next cycle, inst_count=4, fault=0, inst_valid=0.
- READY, rd_en at addr 2 -> next cycle inst_out=0x..03, inst_valid=1. Hold rd_en=0 and inst_ack=0 for 3 cycles -> inst_out/inst_valid unchanged. inst_ack=1 -> inst_valid=0 next cycle.
- Back-to-back reads at addrs 0,1,2 with inst_ack=1 each cycle -> inst_out = 0x..01, 0x..02, 0x..03 on consecutive cycles, inst_valid held at 1.
- Read addr 4 (inst_count=4) -> inst_valid=0, fault=1. A following read at addr 1 -> inst_out=0x..02, fault stays 1.
- load_start and load_done in the same cycle while READY -> state LOADING, ready=0, fault=0, inst_count=0. A wr_en in READY earlier changed neither memory nor count.
- Assert rst=0 mid-read (rd_en=1) -> next edge: all outputs at reset values, including inst_valid=0. Write to addr 1023 in LOADING -> inst_count=1024.
